// File: rtl/rr_mux2_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin packet arbiter:
// FSM state encoding and mux select encoding.
package rr_mux2_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT1 = 2'd1,
      ST_GRANT0 = 2'd2
   } arb_state_e;

   // Mux select values: 0 steers requester 1, 1 steers requester 0.
   localparam logic SEL_REQ1 = 1'b0;
   localparam logic SEL_REQ0 = 1'b1;

   function automatic logic sel_for_state(input arb_state_e st, input logic sel_hold);
      logic sel;
      sel = sel_hold;
      if (st == ST_GRANT1) sel = SEL_REQ1;
      else if (st == ST_GRANT0) sel = SEL_REQ0;
      return sel;
   endfunction

endpackage

// File: rtl/rr_mux2_arbiter_mux.sv
// Single-bit 2:1 mux cell; s_i=0 passes i1_i (requester 1), s_i=1 passes i0_i.
module mux_2to1 (
   input  logic i1_i,
   input  logic i0_i,
   input  logic s_i,
   output logic y_o
);

   assign y_o = s_i ? i0_i : i1_i;

endmodule

// File: rtl/rr_mux2_arbiter.sv
// Round-robin, packet-aware arbiter sharing one registered valid/ready output
// between two requesters, with per-requester packet counters.
module rr_mux2_arbiter
   import rr_mux2_arbiter_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req1_valid_i,
   input  logic [DATA_W-1:0] req1_data_i,
   input  logic              req1_last_i,
   output logic              req1_ready_o,
   input  logic              req0_valid_i,
   input  logic [DATA_W-1:0] req0_data_i,
   input  logic              req0_last_i,
   output logic              req0_ready_o,
   output logic              out_valid_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic              out_last_o,
   input  logic              out_ready_i,
   output logic              sel_o,
   output logic              busy_o,
   output logic [CNT_W-1:0]  pkt_cnt1_o,
   output logic [CNT_W-1:0]  pkt_cnt0_o
);

   arb_state_e        state_q, state_d;
   logic              sel_q, sel_d;
   logic              last_served_q, last_served_d;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic              out_last_q;
   logic [CNT_W-1:0]  cnt1_q, cnt0_q;

   logic              load;
   logic              grant_valid;
   logic              inc1, inc0;
   logic [DATA_W:0]   req1_bus, req0_bus, mux_y;

   // Last flag rides as the top bit so one mux bank steers the whole beat.
   assign req1_bus = {req1_last_i, req1_data_i};
   assign req0_bus = {req0_last_i, req0_data_i};

   generate
      for (genvar gi = 0; gi <= DATA_W; gi++) begin : g_mux
         mux_2to1 u_mux (
            .i1_i (req1_bus[gi]),
            .i0_i (req0_bus[gi]),
            .s_i  (sel_q),
            .y_o  (mux_y[gi])
         );
      end
   endgenerate

   assign load = ~out_valid_q | out_ready_i;

   always_comb begin
      state_d       = state_q;
      last_served_d = last_served_q;
      req1_ready_o  = 1'b0;
      req0_ready_o  = 1'b0;
      grant_valid   = 1'b0;
      inc1          = 1'b0;
      inc0          = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req1_valid_i && req0_valid_i)
               state_d = (last_served_q == SEL_REQ0) ? ST_GRANT1 : ST_GRANT0;
            else if (req1_valid_i)
               state_d = ST_GRANT1;
            else if (req0_valid_i)
               state_d = ST_GRANT0;
         end
         ST_GRANT1: begin
            req1_ready_o = load;
            grant_valid  = req1_valid_i;
            if (req1_valid_i && load && req1_last_i) begin
               inc1          = 1'b1;
               last_served_d = SEL_REQ1;
               state_d       = req0_valid_i ? ST_GRANT0 : ST_IDLE;
            end
         end
         ST_GRANT0: begin
            req0_ready_o = load;
            grant_valid  = req0_valid_i;
            if (req0_valid_i && load && req0_last_i) begin
               inc0          = 1'b1;
               last_served_d = SEL_REQ0;
               state_d       = req1_valid_i ? ST_GRANT1 : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Select is registered alongside the state so it is already correct
      // on the first cycle of a grant; it holds its value through IDLE.
      sel_d = sel_for_state(state_d, sel_q);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         sel_q         <= SEL_REQ0;
         last_served_q <= SEL_REQ0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_last_q    <= 1'b0;
         cnt1_q        <= '0;
         cnt0_q        <= '0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         last_served_q <= last_served_d;
         if (load) begin
            out_valid_q <= grant_valid;
            out_data_q  <= mux_y[DATA_W-1:0];
            out_last_q  <= mux_y[DATA_W];
         end
         if (inc1) cnt1_q <= cnt1_q + CNT_W'(1);
         if (inc0) cnt0_q <= cnt0_q + CNT_W'(1);
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_last_o  = out_last_q;
   assign sel_o       = sel_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign pkt_cnt1_o  = cnt1_q;
   assign pkt_cnt0_o  = cnt0_q;

endmodule
